mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept strobe; request i is accepted in the cycle where req_valid[i] and req_ready[i] are both high.
REQ-007 req_write  input  2  per-requester access type: 1 write, 0 read.
REQ-008 req_addr  input  2xADDR_W  per-requester address.
REQ-009 req_wdata  input  2xDATA_W  per-requester write data.
REQ-010 rsp_valid  output  2  one-cycle response pulse to the owning requester.
REQ-011 rsp_rdata  output  DATA_W  read data; valid when any rsp_valid bit is high; 0 for writes.
REQ-012 mem_address  output  ADDR_W  to memory address.
REQ-013 mem_data_in  output  DATA_W  to memory data_in.
REQ-014 mem_read_write  output  1  to memory read_write: 1 write, 0 read.
REQ-015 mem_chip_en  output  1  to memory chip_en.
REQ-016 mem_data_out  input  DATA_W  from memory data_out; combinational read of mem_address.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP.
- IDLE -> ACCESS on any accept.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-018 req_ready is nonzero only in IDLE and is one-hot: it is set for the arbitration winner among asserted req_valid bits; it is 0 when no request is valid.
REQ-019 Arbitration is round-robin over a 1-bit last_grant register. When both requesters are valid, the requester other than last_grant wins. last_grant updates on every accept.
REQ-020 On accept, the winner's write, addr, wdata and index are registered. The bus is driven only from these registers, never combinationally from req_*.
REQ-021 In ACCESS, mem_chip_en=1 and mem_address, mem_data_in, mem_read_write come from the registers. In IDLE and RESP, mem_chip_en=0, mem_read_write=0, and mem_address/mem_data_in hold their last values.
REQ-022 On a read, mem_data_out is captured at the end of ACCESS into rsp_rdata. On a write, rsp_rdata is set to 0.
REQ-023 In RESP, rsp_valid[owner]=1 for exactly one cycle. rsp_rdata holds its value until the next RESP.
REQ-024 Latency: accept at edge N gives mem_chip_en high in cycle N+1 and rsp_valid in cycle N+2. Peak throughput is one access per 3 cycles.
REQ-025 A requester may deassert or change req_* after its accept without affecting the in-flight access.
REQ-026 While the block is not in IDLE, new req_valid assertions are held off (req_ready=0). No request is dropped or duplicated.

Reset
REQ-027 rst_n low immediately forces the following, including mid-ACCESS or mid-RESP; no response is issued for an aborted access:
- state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0;
- mem_chip_en=0, mem_read_write=0, mem_address=0, mem_data_in=0;
- last_grant=1, so requester 0 wins the first contention.

Configuration
REQ-028 With MEM_ARB_FIXED_PRIO_EN defined, requester 0 always wins contention and last_grant is not implemented. Without it, the round-robin of REQ-019 applies.

Structure
REQ-029 A shared package mem_arb_pkg holds the state enum (IDLE, ACCESS, RESP) and the constants NUM_REQ=2, RW_WRITE=1, RW_READ=0.
REQ-030 One sub-module, mem_arb_rr, holds the grant logic (req_valid, last_grant -> one-hot grant).

Verification
REQ-031 Single read: preload mem[0x10]=0xA5; req_valid=01, write=0, addr=0x10 -> req_ready[0] in the same cycle, mem_chip_en=1 one cycle later, rsp_valid=01 with rsp_rdata=0xA5 two cycles after accept.
REQ-032 Write then read: requester 1 writes 0x3C to 0x20, then reads 0x20 -> mem_read_write=1 during the write ACCESS, write rsp_rdata=0, read rsp_rdata=0x3C.
REQ-033 Contention: req_valid=11 held for 4 accepts after reset -> grant order 0,1,0,1 (0,0,0,0 with MEM_ARB_FIXED_PRIO_EN).
REQ-034 Back-to-back: requester 0 holds valid continuously -> accepts exactly 3 cycles apart, req_ready low during ACCESS and RESP.
REQ-035 Reset mid-operation: assert rst_n=0 during ACCESS -> mem_chip_en falls without waiting for a clock edge, no rsp_valid pulse, and the next request completes normally.
REQ-036 Request change after accept: change req_addr from 0x10 to 0x11 in the cycle after accept -> mem_address remains 0x10.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the FSM state encoding, requester count and read/write encodings.
package mem_arb_pkg;

    localparam int   NUM_REQ  = 2;
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Grant logic: picks one-hot winner among valid requesters (no state, combinational).
// Round-robin on last_grant; MEM_ARB_FIXED_PRIO_EN makes requester 0 always win contention.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant
`ifndef MEM_ARB_FIXED_PRIO_EN
    , input logic              last_grant
`endif
);

    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                grant = 2'b01;
`else
                // The requester that did not win last time goes first.
                grant = last_grant ? 2'b01 : 2'b10;
`endif
            end
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory; accept->chip_en 1 cycle, ->rsp 2 cycles.
// Holds req_ready low outside IDLE (one access per 3 cycles); MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_data_in,
    output logic                        mem_read_write,
    output logic                        mem_chip_en,
    input  logic [DATA_W-1:0]           mem_data_out
);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_REQ-1:0]  grant;
    logic                accept;
    logic                win_idx;

    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                owner_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    mem_arb_rr u_rr (
        .req_valid (req_valid),
        .grant     (grant)
    );
`else
    logic last_grant;

    mem_arb_rr u_rr (
        .req_valid  (req_valid),
        .grant      (grant),
        .last_grant (last_grant)
    );

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= win_idx;
        end
    end
`endif

    assign win_idx = grant[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        req_ready      = '0;
        accept         = 1'b0;
        mem_chip_en    = 1'b0;
        mem_read_write = RW_READ;
        rsp_valid      = '0;
        case (state)
            IDLE: begin
                // Gated by rst_n so nothing looks accepted while reset is held.
                if (rst_n) begin
                    req_ready = grant;
                end
                accept = |(req_valid & req_ready);
                if (accept) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_chip_en    = 1'b1;
                mem_read_write = wr_q;
                state_nxt      = RESP;
            end
            RESP: begin
                rsp_valid = idx_to_onehot(owner_q);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The memory bus comes only from these registers, so requesters may change req_* after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            owner_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= req_write[win_idx];
                addr_q  <= addr_arr[win_idx];
                wdata_q <= wdata_arr[win_idx];
                owner_q <= win_idx;
            end
            if (state == ACCESS) begin
                rdata_q <= (wr_q == RW_WRITE) ? '0 : mem_data_out;
            end
        end
    end

    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;
    assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a cycle-count reference model and a memory model.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_write = '0;
    logic [1:0]      req_ready;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_data_in;
    logic [DW-1:0]   mem_data_out;
    logic            mem_read_write;
    logic            mem_chip_en;

    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];

    assign mem_data_out = env_mem[mem_address];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_read_write (mem_read_write),
        .mem_chip_en    (mem_chip_en),
        .mem_data_out   (mem_data_out)
    );

    int total = 0;
    int bad = 0;

    // Reference model: everything is timed relative to the cycle of the last accept.
    int         cyc = 0;
    int         last_acc = -100;
    int         exp_last = 1;
    logic       p_wr = 1'b0;
    logic       p_own = 1'b0;
    logic [7:0] exp_addr = '0;
    logic [7:0] exp_wdata = '0;
    logic [7:0] p_rdata = '0;
    logic [7:0] hold = '0;
    int         grants [$];
    int         acc_cyc [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check before posedge, advance model at posedge.
    task automatic step(input logic [1:0] v, input logic [1:0] w,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1);
        int         win;
        logic       exp_ce;
        logic       we;
        logic [7:0] wa;
        logic [7:0] wd;
        logic [1:0] exp_rsp;
        req_valid = v;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        win = -1;
        if (cyc >= last_acc + 3 && v != 2'b00) begin
            if (v == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = 1 - exp_last;
`endif
            end else begin
                win = v[1] ? 1 : 0;
            end
        end
        check("ready", 32'(req_ready), (win < 0) ? 32'd0 : (32'd1 << win));
        exp_ce = (cyc == last_acc + 1);
        check("chip_en", 32'(mem_chip_en), 32'(exp_ce));
        check("rw", 32'(mem_read_write), 32'(exp_ce && p_wr));
        check("addr", 32'(mem_address), 32'(exp_addr));
        check("wdata", 32'(mem_data_in), 32'(exp_wdata));
        exp_rsp = 2'b00;
        if (cyc == last_acc + 2) begin
            hold    = p_rdata;
            exp_rsp = p_own ? 2'b10 : 2'b01;
        end
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        check("rdata", 32'(rsp_rdata), 32'(hold));
        we = mem_chip_en && mem_read_write;
        wa = mem_address;
        wd = mem_data_in;
        @(posedge clk);
        if (we) env_mem[wa] = wd;
        if (exp_ce && p_wr) ref_mem[exp_addr] = exp_wdata;
        if (win >= 0) begin
            last_acc  = cyc;
            exp_last  = win;
            p_own     = (win == 1);
            p_wr      = w[win];
            exp_addr  = (win == 1) ? a1 : a0;
            exp_wdata = (win == 1) ? d1 : d0;
            p_rdata   = p_wr ? 8'h00 : ref_mem[exp_addr];
            grants.push_back(win);
            acc_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_chip_en", 32'(mem_chip_en), 32'd0);
        check("rst_rw", 32'(mem_read_write), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_wdata", 32'(mem_data_in), 32'd0);
        last_acc  = -100;
        exp_last  = 1;
        hold      = '0;
        exp_addr  = '0;
        exp_wdata = '0;
        p_wr      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        env_mem[8'h10] = 8'hA5;
        ref_mem[8'h10] = 8'hA5;

        #2;
        req_valid = 2'b11;
        do_reset();

        // Single read of a preloaded location.
        step(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
        #1 check("rd_chip_en", 32'(mem_chip_en), 32'd1);
        idle(1);
        #1 check("rd_rsp", 32'(rsp_valid), 32'd1);
        check("rd_data", 32'(rsp_rdata), 32'hA5);
        idle(1);

        // Requester 1 writes then reads back.
        step(2'b10, 2'b10, 8'h00, 8'h20, 8'h00, 8'h3C);
        #1 check("wr_rw", 32'(mem_read_write), 32'd1);
        idle(1);
        #1 check("wr_rdata", 32'(rsp_rdata), 32'd0);
        idle(1);
        step(2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00);
        idle(1);
        #1 check("rb_rsp", 32'(rsp_valid), 32'd2);
        check("rb_data", 32'(rsp_rdata), 32'h3C);
        idle(1);

        // Address changed by the requester right after accept.
        step(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
        step(2'b01, 2'b00, 8'h11, 8'h00, 8'h00, 8'h00);
        check("addr_hold", 32'(mem_address), 32'h10);
        idle(3);

        // Contention from reset.
        do_reset();
        grants.delete();
        for (int i = 0; i < 12; i++) step(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
        check("cont_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            check("cont_order", 32'(grants[i]), 32'd0);
`else
            check("cont_order", 32'(grants[i]), 32'(i % 2));
`endif
        end
        idle(3);

        // Back-to-back from a single requester.
        acc_cyc.delete();
        for (int i = 0; i < 10; i++) step(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00);
        check("b2b_count", 32'(acc_cyc.size()), 32'd4);
        for (int i = 1; i < 4 && i < acc_cyc.size(); i++)
            check("b2b_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        idle(3);

        // Reset during ACCESS aborts the access.
        step(2'b01, 2'b00, 8'h30, 8'h00, 8'h00, 8'h00);
        #1 check("abort_pre_ce", 32'(mem_chip_en), 32'd1);
        do_reset();
        idle(4);
        step(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
        idle(1);
        #1 check("post_rst_data", 32'(rsp_rdata), 32'hA5);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                 8'($urandom), 8'($urandom));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
